regfile_capture: RTL
====================

# regfile_capture

Serial-to-parallel receiver for the self-test scan chain. It sits at the far end of the 192-bit register-file shifter and watches the same `en` control and the registered serial bit stream, MSB first. It rebuilds each shifted word, compares it against an expected word, and keeps saturating pass/fail/abort counters for the self-test controller.

## Interface
- `WIDTH`, 192: word length in bits; must be ≥ 2.
- `CNT_W`, 16: width of the saturating statistics counters.

Ports:
- `clk`  in  1  single clock for the block
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  shifter control; low = shifter loads a parallel word; high = shifter shifts
- `shift_in`  in  1  shifter's registered serial output
- `expected`  in  WIDTH  golden word; sampled only on the final capture edge
- `data_out`  out  WIDTH  last fully captured word
- `valid`  out  1  one-cycle pulse: `data_out`/`match` updated
- `match`  out  1  `data_out == expected` for the last word
- `busy`  out  1  high while in CAPTURE
- `abort`  out  1  one-cycle pulse: capture cut short by `en` low
- `word_cnt`  out  CNT_W  words completed, saturating
- `err_cnt`  out  CNT_W  words completed with `match`=0, saturating
- `abort_cnt`  out  CNT_W  aborted captures, saturating

## Operation
- Shifter behaviour this block relies on:
  - Edge L with `en`=0 loads word D.
  - For every edge L+1+j with `en`=1, `shift_out` becomes D[WIDTH-1-j].
  - `shift_in` sampled at edge L+2+j therefore equals D[WIDTH-1-j], for j = 0..WIDTH-1.
- State: 2-bit FSM, `WIDTH`-bit shift register `sr`, bit counter `cnt` of width $clog2(WIDTH).
- IDLE:
  - `en`=0 sampled → LOAD.
  - Otherwise stay. Trailing zeros shifted out after a word are ignored.
- LOAD:
  - `en`=0 → stay.
  - `en`=1 → CAPTURE, `cnt`←0. This is edge L+1; no bit is captured on it.
- CAPTURE, on each edge:
  - `sr` ← {`sr`[WIDTH-2:0], `shift_in`}; `cnt`++.
  - If `cnt` < WIDTH-1 and `en`=0: discard `sr`, pulse `abort`, `abort_cnt`++, go to LOAD. This edge is a new load.
  - If `cnt` == WIDTH-1, this is the final bit. Regardless of `en`:
    - `data_out` ← {`sr`[WIDTH-2:0], `shift_in`}.
    - `match` ← (that value == `expected`).
    - Pulse `valid`; `word_cnt`++; `err_cnt`++ if mismatch.
    - Next state: LOAD if `en`=0 (back-to-back load), else IDLE.
- Counters saturate at all-ones and never wrap.
- `data_out` and `match` hold their value between `valid` pulses.
- `busy` = (state == CAPTURE), registered with the state.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`):
  - State = IDLE, `sr` = 0, `cnt` = 0.
  - All outputs = 0: `data_out`, `valid`, `match`, `busy`, `abort`, and all three counters.
- Reset asserted mid-capture: partial word discarded; no `valid`, no `abort`, no counter change beyond the clear.
- Latency: load edge L → `valid` high in the cycle after edge L+WIDTH+1 (L+193 for the default). `valid` lasts exactly one cycle.
- Back-to-back: `en` low exactly at edge L+WIDTH+1 gives word 1 `valid` and starts word 2. Word 2 `valid` follows after edge L+2·(WIDTH+1).
- `en` low on the final capture edge is not an abort.
- `en` low on any earlier CAPTURE edge is an abort.
- `valid` and `abort` are never high in the same cycle.
- `en` low for several consecutive cycles: only the last low edge defines L.

## Test plan
- Load D=192'h5A5A…C3 with `expected`=D, then `en` high for 200 cycles → `valid` one cycle after edge L+193, `data_out`=D, `match`=1, `word_cnt`=1, `err_cnt`=0, no further `valid`.
- Same stimulus with `expected`=D^1 (bit 0 flipped) → `match`=0, `err_cnt`=1. Repeat with all-ones and all-zeros words → `match`=1 each time.
- Load, `en` high, then `en` low at edge L+50 → `abort` pulse, `abort_cnt`=1, no `valid`, `data_out` unchanged. The second word then completes normally at its own L'+193.
- Back-to-back: three words, `en` low exactly at each completion edge → `valid` at L+193, L+386, L+579 with correct data; `word_cnt`=3, `abort_cnt`=0.
- Assert `rst_n` low asynchronously at edge L+100 → all outputs 0 immediately. After release, a fresh load/shift captures correctly.
- Force `word_cnt` near saturation (CNT_W=4, 17 words) → `word_cnt` holds at 15.

Source files
------------

// File: rtl/regfile_capture.sv
// Serial-to-parallel receiver at the tail of the self-test scan shifter.
// Rebuilds each word MSB-first, compares it against a golden word and keeps saturating statistics.
module regfile_capture #(
  parameter int WIDTH = 192,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             match,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic [WIDTH-1:0] sr_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sr_next = {sr_q[WIDTH-2:0], shift_in};

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    match_d     = match_q;
    valid_d     = 1'b0;
    abort_d     = 1'b0;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;
    abort_cnt_d = abort_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!en) state_d = LOAD;
      end
      LOAD: begin
        // The first edge with en high only moves the loaded word's MSB onto shift_in.
        if (en) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        sr_d  = sr_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Final bit: the word completes whatever en does; en low here is a back-to-back load.
          data_d     = sr_next;
          match_d    = (sr_next == expected);
          valid_d    = 1'b1;
          word_cnt_d = sat_inc(word_cnt_q);
          if (sr_next != expected) err_cnt_d = sat_inc(err_cnt_q);
          cnt_d      = '0;
          state_d    = en ? IDLE : LOAD;
        end else if (!en) begin
          sr_d        = '0;
          cnt_d       = '0;
          abort_d     = 1'b1;
          abort_cnt_d = sat_inc(abort_cnt_q);
          state_d     = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      abort_q     <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      abort_q     <= abort_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign match     = match_q;
  assign busy      = (state_q == CAPTURE);
  assign abort     = abort_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule
